addsub_nibble_seq: RTL and testbench



---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_nib_slice.sv | 23 ++
 rtl/addsub_nibble_seq.sv | 132 +++++++++++++
 tb/tb_addsub_nibble_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits handled per slice cycle.
  localparam int NIB_W = 4;

endpackage

// File: rtl/addsub_nib_slice.sv
// 4-bit ripple adder slice: s4/co = a4 + b4 + ci.
// Latency: combinational.
// Backpressure: none (pure datapath).
module addsub_nib_slice
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  logic [NIB_W:0] sum;

  // Widen by one bit so the carry out falls into the MSB.
  always_comb begin
    sum = {1'b0, a4} + {1'b0, b4} + {{NIB_W{1'b0}}, ci};
    s4  = sum[NIB_W-1:0];
    co  = sum[NIB_W];
  end

endmodule

// File: rtl/addsub_nibble_seq.sv
// Nibble-serial WIDTH-bit add/subtract, LSB nibble first, through one 4-bit slice.
// Latency: accept at edge k -> out_valid after edge k+NIB; one op per NIB+2 cycles.
// Backpressure: in_ready only in IDLE; result/flags hold in DONE until out_ready.
// Optional: define ADDSUB_SAT_EN to clamp the result to the signed limit on overflow.
module addsub_nibble_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("addsub_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;      // b, or ~b for subtract
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;

  logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
  logic               nib_co;
  logic               last_nib;
  logic               ovf_next;
  logic [WIDTH-1:0]   raw_final;
  logic [WIDTH-1:0]   final_res;

  assign nib_a    = a_q[{idx_q, 2'b00} +: NIB_W];
  assign nib_b    = b_q[{idx_q, 2'b00} +: NIB_W];
  assign last_nib = (state_q == RUN) && (idx_q == LAST_IDX);

  addsub_nib_slice u_slice (
    .a4 (nib_a),
    .b4 (nib_b),
    .ci (carry_q),
    .s4 (nib_s),
    .co (nib_co)
  );

  // Assemble the full result as it will look after the final nibble, plus overflow/clamp.
  always_comb begin
    raw_final = result;
    raw_final[{idx_q, 2'b00} +: NIB_W] = nib_s;
    ovf_next  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIB_W-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    // Both operands share a_q's sign on overflow, so it picks the limit.
    final_res = ovf_next ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : raw_final;
`else
    final_res = raw_final;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, nibble stepping and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q     <= a;
        b_q     <= (op_sub == OP_SUB) ? ~b : b;
        carry_q <= (op_sub == OP_ADD) ? 1'b0 : 1'b1;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        carry_q <= nib_co;
        idx_q   <= idx_q + IDX_W'(1);
        if (last_nib) begin
          result   <= final_res;
          cout     <= nib_co;
          overflow <= ovf_next;
          zero     <= (final_res == '0);
        end else begin
          result[{idx_q, 2'b00} +: NIB_W] <= nib_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq at WIDTH=16.
// Latency: checks out_valid exactly 4 edges after accept.
// Backpressure: holds out_ready low in DONE with a pending op.
module tb_addsub_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_nibble_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
  localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
`else
  localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op, wait (bounded) for the accept edge, then scramble inputs.
  task automatic start_op(input logic sub, input logic [15:0] av, input logic [15:0] bv);
    int n;
    in_valid = 1'b1;
    op_sub   = sub;
    a        = av;
    b        = bv;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_sub   = 1'($urandom);
    a        = 16'($urandom);
    b        = 16'($urandom);
    check("busy_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [15:0] r,
                           input logic c, input logic o, input logic z);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_cout"}, 32'(cout), 32'(c));
    check({tag, "_ovf"}, 32'(overflow), 32'(o));
    check({tag, "_zero"}, 32'(zero), 32'(z));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    start_op(1'b0, 16'h1234, 16'h0FFF);
    wait_done("add1");
    check_res("add1", 16'h2233, 1'b0, 1'b0, 1'b0);
    release_out();

    start_op(1'b1, 16'h0005, 16'h0007);
    wait_done("sub57");
    check_res("sub57", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    release_out();

    start_op(1'b1, 16'h0007, 16'h0005);
    wait_done("sub75");
    check_res("sub75", 16'h0002, 1'b1, 1'b0, 1'b0);
    release_out();

    start_op(1'b0, 16'hFFFF, 16'h0001);
    wait_done("addwrap");
    check_res("addwrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out();

    start_op(1'b1, 16'h8000, 16'h0001);
    wait_done("subovf");
    check_res("subovf", EXP_SUB_OVF, 1'b1, 1'b1, 1'b0);
    release_out();

    start_op(1'b0, 16'h7FFF, 16'h0001);
    wait_done("addovf");
    check_res("addovf", EXP_ADD_OVF, 1'b0, 1'b1, 1'b0);
    release_out();

    // Backpressure: a new op waits while DONE is held.
    start_op(1'b0, 16'h1111, 16'h2222);
    wait_done("bp");
    in_valid = 1'b1; op_sub = 1'b0; a = 16'h0100; b = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_result", 32'(result), 32'h3333);
      check("bp_hold_flags", {29'd0, cout, overflow, zero}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pending_taken", 32'(in_ready), 32'd0);
    wait_done("bp_pending");
    check_res("bp_pending", 16'h0300, 1'b0, 1'b0, 1'b0);
    release_out();

    // Asynchronous reset in the middle of RUN (nibble index 2).
    start_op(1'b0, 16'h1234, 16'h1111);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result_rel", 32'(result), 32'd0);
    @(posedge clk); #1;
    start_op(1'b0, 16'h0001, 16'h0001);
    wait_done("after_rst");
    check_res("after_rst", 16'h0002, 1'b0, 1'b0, 1'b0);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
